// File: rtl/kevin_serial_detector.sv
// Serial word detector: assembles WIDTH-bit words from a bit stream and checks each word against MASK.
// Outputs are registered, one cycle after the completing bit. There is no backpressure: a bit is taken whenever bit_valid=1 and clr=0.
module kevin_serial_detector #(
  parameter int                    WIDTH     = 4,
  parameter logic [(1<<WIDTH)-1:0] MASK      = 16'h56E2,
  parameter int                    MSB_FIRST = 1,
  parameter int                    SLIDING   = 0,
  parameter int                    CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             word_valid,
  output logic [WIDTH-1:0] word,
  output logic             hit,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int           FW   = $clog2(WIDTH);
  localparam logic [FW-1:0] LAST = FW'(WIDTH - 1);

  typedef enum logic {FILL, STREAM} state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [FW-1:0]    fill;
  logic             done;
  logic             mask_hit;

  always_comb begin
    sr_next = sr;
    if (MSB_FIRST != 0) sr_next = {sr[WIDTH-2:0], bit_in};
    else                sr_next = {bit_in, sr[WIDTH-1:1]};
  end

  // In STREAM every accepted bit closes a window; in FILL only the last bit of a frame does.
  assign done     = (state == STREAM) || (fill == LAST);
  assign mask_hit = MASK[sr_next];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      sr         <= '0;
      fill       <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      hit        <= 1'b0;
      word_cnt   <= '0;
      hit_cnt    <= '0;
    end else begin
      word_valid <= 1'b0;
      hit        <= 1'b0;
      if (clr) begin
        state    <= FILL;
        sr       <= '0;
        fill     <= '0;
        word_cnt <= '0;
        hit_cnt  <= '0;
      end else if (bit_valid) begin
        sr <= sr_next;
        if (state == FILL && !done) fill <= fill + 1'b1;
        if (done) begin
          word       <= sr_next;
          word_valid <= 1'b1;
          hit        <= mask_hit;
          if (word_cnt != '1) word_cnt <= word_cnt + 1'b1;
          if (mask_hit && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
          if (SLIDING == 0) begin
            fill <= '0;
            sr   <= '0;
          end else begin
            fill  <= '0;
            state <= STREAM;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_kevin_serial_detector.sv
// Scoreboard bench: four detector configurations driven with directed bit sequences.
module tb_kevin_serial_detector;

  typedef struct {
    int w;
    int h;
    int wc;
    int hc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst_n3 = 1'b0;
  logic       clr [4];
  logic       bv  [4];
  logic       bi  [4];
  logic       wv  [4];
  logic       hit [4];
  logic [3:0] wd  [4];
  logic [7:0] wc  [4];
  logic [7:0] hc  [4];
  logic [1:0] wc3, hc3;

  exp_t q [4][$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  kevin_serial_detector u_def (.clk(clk), .rst_n(rst_n), .clr(clr[0]), .bit_valid(bv[0]), .bit_in(bi[0]),
    .word_valid(wv[0]), .word(wd[0]), .hit(hit[0]), .word_cnt(wc[0]), .hit_cnt(hc[0]));
  kevin_serial_detector #(.MSB_FIRST(0)) u_lsb (.clk(clk), .rst_n(rst_n), .clr(clr[1]), .bit_valid(bv[1]),
    .bit_in(bi[1]), .word_valid(wv[1]), .word(wd[1]), .hit(hit[1]), .word_cnt(wc[1]), .hit_cnt(hc[1]));
  kevin_serial_detector #(.SLIDING(1)) u_sld (.clk(clk), .rst_n(rst_n), .clr(clr[2]), .bit_valid(bv[2]),
    .bit_in(bi[2]), .word_valid(wv[2]), .word(wd[2]), .hit(hit[2]), .word_cnt(wc[2]), .hit_cnt(hc[2]));
  kevin_serial_detector #(.CNT_W(2)) u_sat (.clk(clk), .rst_n(rst_n3), .clr(clr[3]), .bit_valid(bv[3]),
    .bit_in(bi[3]), .word_valid(wv[3]), .word(wd[3]), .hit(hit[3]), .word_cnt(wc3), .hit_cnt(hc3));

  assign wc[3] = {6'b0, wc3};
  assign hc[3] = {6'b0, hc3};

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic expect_word(input int i, input int w, input int h, input int wcnt, input int hcnt);
    exp_t e;
    e.w = w; e.h = h; e.wc = wcnt; e.hc = hcnt;
    q[i].push_back(e);
  endtask

  // Drives one bit across the next rising edge; returns on the following falling edge.
  task automatic send(input int i, input logic b);
    bv[i] = 1'b1;
    bi[i] = b;
    @(negedge clk);
    bv[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wv[i]) begin
        if (q[i].size() == 0) begin
          chk($sformatf("unexpected_pulse_d%0d", i), 1, 0);
        end else begin
          exp_t e;
          e = q[i].pop_front();
          chk($sformatf("word_d%0d", i), int'(wd[i]), e.w);
          chk($sformatf("hit_d%0d", i), int'(hit[i]), e.h);
          chk($sformatf("word_cnt_d%0d", i), int'(wc[i]), e.wc);
          chk($sformatf("hit_cnt_d%0d", i), int'(hc[i]), e.hc);
        end
      end else if (hit[i]) begin
        chk($sformatf("hit_without_valid_d%0d", i), 1, 0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      clr[i] = 1'b0; bv[i] = 1'b0; bi[i] = 1'b0;
    end
    idle(3);
    rst_n = 1'b1;
    rst_n3 = 1'b1;
    idle(1);

    chk("reset_word_valid", int'(wv[0]), 0);
    chk("reset_word", int'(wd[0]), 0);
    chk("reset_word_cnt", int'(wc[0]), 0);
    chk("reset_hit_cnt", int'(hc[0]), 0);

    // MSB-first frame 0101 -> 5, a member
    expect_word(0, 5, 1, 1, 1);
    send(0, 0); send(0, 1); send(0, 0); send(0, 1);
    idle(1);
    chk("t1_pulse_drops", int'(wv[0]), 0);
    chk("t1_word_holds", int'(wd[0]), 5);

    // Bubbled frame 1000 -> 8, not a member
    expect_word(0, 8, 0, 2, 1);
    send(0, 1); idle(1); send(0, 0); idle(1); send(0, 0); idle(1); send(0, 0);
    idle(2);
    chk("t2_hit_cnt_kept", int'(hc[0]), 1);

    // LSB-first: 1,0,1,0 -> 5 then 0,1,1,0 -> 6
    expect_word(1, 5, 1, 1, 1);
    send(1, 1); send(1, 0); send(1, 1); send(1, 0);
    expect_word(1, 6, 1, 2, 2);
    send(1, 0); send(1, 1); send(1, 1); send(1, 0);
    idle(2);

    // Sliding window over 1,1,0,0,1,1 -> 12, 9, 3
    expect_word(2, 12, 1, 1, 1);
    expect_word(2, 9, 1, 2, 2);
    expect_word(2, 3, 0, 3, 2);
    send(2, 1); send(2, 1); send(2, 0); send(2, 0); send(2, 1); send(2, 1);
    idle(2);
    chk("t4_word_cnt", int'(wc[2]), 3);
    chk("t4_hit_cnt", int'(hc[2]), 2);

    // Clear wins over a valid bit and discards the partial frame
    send(0, 1); send(0, 1);
    clr[0] = 1'b1; bv[0] = 1'b1; bi[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0; bv[0] = 1'b0;
    chk("t5_clr_word_cnt", int'(wc[0]), 0);
    chk("t5_clr_hit_cnt", int'(hc[0]), 0);
    chk("t5_clr_word_valid", int'(wv[0]), 0);
    chk("t5_clr_word_holds", int'(wd[0]), 8);
    expect_word(0, 6, 1, 1, 1);
    send(0, 0); send(0, 1); send(0, 1); send(0, 0);
    idle(2);

    // Counter saturation with CNT_W=2
    for (int k = 1; k <= 6; k++) begin
      expect_word(3, 1, 1, (k > 3) ? 3 : k, (k > 3) ? 3 : k);
      send(3, 0); send(3, 0); send(3, 0); send(3, 1);
    end
    idle(1);
    chk("t6_word_cnt_sat", int'(wc[3]), 3);
    chk("t6_hit_cnt_sat", int'(hc[3]), 3);
    chk("t6_word_before_rst", int'(wd[3]), 1);

    // Asynchronous reset mid-frame, between clock edges
    send(3, 1); send(3, 0);
    #2 rst_n3 = 1'b0;
    #1;
    chk("t6_rst_word", int'(wd[3]), 0);
    chk("t6_rst_word_cnt", int'(wc[3]), 0);
    chk("t6_rst_hit_cnt", int'(hc[3]), 0);
    chk("t6_rst_word_valid", int'(wv[3]), 0);
    @(negedge clk);
    rst_n3 = 1'b1;
    idle(1);
    expect_word(3, 12, 1, 1, 1);
    send(3, 1); send(3, 1); send(3, 0); send(3, 0);
    idle(3);

    for (int i = 0; i < 4; i++)
      chk($sformatf("pending_words_d%0d", i), q[i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
